multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Consumes the one-hot instruction-class flags from the opcode

---
 rtl/multicycle_ctrl_if.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_ctrl_if : decoder/memory handshake and control bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             is_r_type;
  logic             is_i_type;
  logic             is_load;
  logic             is_store;
  logic             is_branch;
  logic             is_jump;
  logic             br_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             alu_src_imm;
  logic             dmem_req;
  logic             dmem_we;
  logic             instr_done;
  logic             illegal;
  logic             timeout;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_cnt;

  // master: the controller; slave: decoder, comparator and memories
  modport master (
    input  is_r_type, is_i_type, is_load, is_store, is_branch, is_jump,
           br_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_imm,
           dmem_req, dmem_we, instr_done, illegal, timeout, state, retired_cnt
  );

  modport slave (
    output is_r_type, is_i_type, is_load, is_store, is_branch, is_jump,
           br_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_imm,
           dmem_req, dmem_we, instr_done, illegal, timeout, state, retired_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_ctrl : RV32I multi-cycle control FSM with wait timeout |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int MAX_WAIT     = 15,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 32,
  parameter bit HALT_ON_TRAP = 1'b1
) (
  input wire clk,
  input wire rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_FETCH  = 3'd1;
  localparam logic [2:0] C_DECODE = 3'd2;
  localparam logic [2:0] C_EXEC   = 3'd3;
  localparam logic [2:0] C_MEM    = 3'd4;
  localparam logic [2:0] C_WB     = 3'd5;
  localparam logic [2:0] C_TRAP   = 3'd6;
  localparam logic [2:0] C_HALT   = 3'd7;

  localparam logic [1:0] C_PC_4    = 2'b00;
  localparam logic [1:0] C_PC_BR   = 2'b01;
  localparam logic [1:0] C_PC_JMP  = 2'b10;
  localparam logic [1:0] C_PC_TRAP = 2'b11;
  localparam logic [1:0] C_WB_ALU  = 2'b00;
  localparam logic [1:0] C_WB_MEM  = 2'b01;
  localparam logic [1:0] C_WB_PC4  = 2'b10;

  localparam int C_R  = 5;
  localparam int C_I  = 4;
  localparam int C_LD = 3;
  localparam int C_ST = 2;
  localparam int C_BR = 1;
  localparam int C_JP = 0;

  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [5:0]        r_cls;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        w_flags;
  logic              w_onehot;
  logic              w_set_ill;
  logic              w_set_to;

  logic       w_imem_req;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_sel;
  logic       w_rf_we;
  logic [1:0] w_wb_sel;
  logic       w_alu_src_imm;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_instr_done;

  assign w_flags  = {bus.is_r_type, bus.is_i_type, bus.is_load,
                     bus.is_store, bus.is_branch, bus.is_jump};
  assign w_onehot = (w_flags != 6'd0) && ((w_flags & (w_flags - 6'd1)) == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      C_IDLE:   w_next = C_FETCH;
      C_FETCH: begin
        if (bus.imem_ready) begin
          w_next = C_DECODE;
        end else if (r_wait == C_MAX_WAIT) begin
          w_next   = C_TRAP;
          w_set_to = 1'b1;
        end
      end
      C_DECODE: begin
        if (w_onehot) begin
          w_next = C_EXEC;
        end else begin
          w_next    = C_TRAP;
          w_set_ill = 1'b1;
        end
      end
      C_EXEC: begin
        if (r_cls[C_BR] || r_cls[C_JP]) begin
          w_next = C_FETCH;
        end else if (r_cls[C_LD] || r_cls[C_ST]) begin
          w_next = C_MEM;
        end else if (r_cls[C_R] || r_cls[C_I]) begin
          w_next = C_WB;
        end else begin
          // Unreachable with a one-hot latch; treat a corrupted class as illegal.
          w_next    = C_TRAP;
          w_set_ill = 1'b1;
        end
      end
      C_MEM: begin
        if (bus.dmem_ready) begin
          w_next = r_cls[C_ST] ? C_FETCH : C_WB;
        end else if (r_wait == C_MAX_WAIT) begin
          w_next   = C_TRAP;
          w_set_to = 1'b1;
        end
      end
      C_WB:     w_next = C_FETCH;
      C_TRAP:   w_next = HALT_ON_TRAP ? C_HALT : C_FETCH;
      C_HALT:   w_next = C_HALT;
      default:  w_next = C_IDLE;
    endcase
  end

  always_comb begin
    w_imem_req    = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_sel      = C_PC_4;
    w_rf_we       = 1'b0;
    w_wb_sel      = C_WB_ALU;
    w_alu_src_imm = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_instr_done  = 1'b0;
    case (r_state)
      C_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_we    = bus.imem_ready;
      end
      C_EXEC: begin
        w_alu_src_imm = r_cls[C_I] | r_cls[C_LD] | r_cls[C_ST];
        if (r_cls[C_BR]) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = bus.br_taken ? C_PC_BR : C_PC_4;
          w_instr_done = 1'b1;
        end
        if (r_cls[C_JP]) begin
          w_rf_we      = 1'b1;
          w_wb_sel     = C_WB_PC4;
          w_pc_we      = 1'b1;
          w_pc_sel     = C_PC_JMP;
          w_instr_done = 1'b1;
        end
      end
      C_MEM: begin
        w_dmem_req    = 1'b1;
        w_dmem_we     = r_cls[C_ST];
        w_alu_src_imm = 1'b1;
        // Stores retire straight from MEM; loads still need WB.
        if (bus.dmem_ready && r_cls[C_ST]) begin
          w_pc_we      = 1'b1;
          w_instr_done = 1'b1;
        end
      end
      C_WB: begin
        w_rf_we      = 1'b1;
        w_wb_sel     = r_cls[C_LD] ? C_WB_MEM : C_WB_ALU;
        w_pc_we      = 1'b1;
        w_instr_done = 1'b1;
      end
      C_TRAP: begin
        w_pc_we  = 1'b1;
        w_pc_sel = C_PC_TRAP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls     <= 6'd0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == C_DECODE) begin
        r_cls <= w_flags;
      end
      // Any state change clears the wait count, so FETCH and MEM always start from zero.
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (r_state == C_FETCH || r_state == C_MEM) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_set_ill) begin
        r_illegal <= 1'b1;
      end
      if (w_set_to) begin
        r_timeout <= 1'b1;
      end
      if (w_instr_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.imem_req    = w_imem_req;
  assign bus.ir_we       = w_ir_we;
  assign bus.pc_we       = w_pc_we;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.rf_we       = w_rf_we;
  assign bus.wb_sel      = w_wb_sel;
  assign bus.alu_src_imm = w_alu_src_imm;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.dmem_we     = w_dmem_we;
  assign bus.instr_done  = w_instr_done;
  assign bus.illegal     = r_illegal;
  assign bus.timeout     = r_timeout;
  assign bus.state       = r_state;
  assign bus.retired_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multicycle_ctrl : directed cycle-trace scoreboard bench        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_multicycle_ctrl;

    localparam logic [2:0] C_IDLE = 3'd0, C_FETCH = 3'd1, C_DECODE = 3'd2, C_EXEC = 3'd3;
    localparam logic [2:0] C_MEM  = 3'd4, C_WB = 3'd5, C_TRAP = 3'd6, C_HALT = 3'd7;

    // Flag order {r, i, load, store, branch, jump}
    localparam logic [5:0] F_R = 6'b100000, F_I = 6'b010000, F_LD = 6'b001000;
    localparam logic [5:0] F_ST = 6'b000100, F_BR = 6'b000010, F_JP = 6'b000001;

    // Control order {imem_req, ir_we, pc_we, pc_sel[1:0], rf_we, wb_sel[1:0], alu_src_imm, dmem_req, dmem_we, instr_done}
    localparam logic [11:0] K_IMREQ = 12'h800, K_IRWE = 12'h400, K_PCWE = 12'h200;
    localparam logic [11:0] K_PCS_BR = 12'h080, K_PCS_JP = 12'h100, K_PCS_TR = 12'h180;
    localparam logic [11:0] K_RFWE = 12'h040, K_WB_LD = 12'h010, K_WB_PC = 12'h020;
    localparam logic [11:0] K_IMM = 12'h008, K_DREQ = 12'h004, K_DWE = 12'h002, K_DONE = 12'h001;

    typedef struct {
        int          sel;
        int          step;
        logic [2:0]  st;
        logic [11:0] ctl;
        logic        ill;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus_a ();
    multicycle_ctrl_if #(.CNT_W(4))  bus_b ();

    multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(4), .CNT_W(32), .HALT_ON_TRAP(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a.master)
    );

    multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(4), .CNT_W(4), .HALT_ON_TRAP(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.master)
    );

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          sel      = 0;
    int          step     = 0;
    logic        exp_ill  = 1'b0;
    logic        exp_to   = 1'b0;
    logic [31:0] exp_cnt  = 32'd0;
    logic [31:0] cnt_mask = 32'hFFFF_FFFF;

    // Monitor: pops one expected cycle per falling edge and compares it against the selected DUT.
    always @(negedge clk) begin
        exp_t        e;
        logic [2:0]  a_st;
        logic [11:0] a_ctl;
        logic        a_ill;
        logic        a_to;
        logic [31:0] a_cnt;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel == 0) begin
                a_st  = bus_a.state;
                a_ctl = {bus_a.imem_req, bus_a.ir_we, bus_a.pc_we, bus_a.pc_sel, bus_a.rf_we, bus_a.wb_sel,
                         bus_a.alu_src_imm, bus_a.dmem_req, bus_a.dmem_we, bus_a.instr_done};
                a_ill = bus_a.illegal;
                a_to  = bus_a.timeout;
                a_cnt = bus_a.retired_cnt;
            end else begin
                a_st  = bus_b.state;
                a_ctl = {bus_b.imem_req, bus_b.ir_we, bus_b.pc_we, bus_b.pc_sel, bus_b.rf_we, bus_b.wb_sel,
                         bus_b.alu_src_imm, bus_b.dmem_req, bus_b.dmem_we, bus_b.instr_done};
                a_ill = bus_b.illegal;
                a_to  = bus_b.timeout;
                a_cnt = {28'd0, bus_b.retired_cnt};
            end
            checks = checks + 1;
            if ({a_st, a_ctl, a_ill, a_to, a_cnt} !== {e.st, e.ctl, e.ill, e.to, e.cnt}) begin
                failures = failures + 1;
                $display("FAIL step%0d dut%0d: got st=%0d ctl=%03h ill=%0b to=%0b cnt=%0d, expected st=%0d ctl=%03h ill=%0b to=%0b cnt=%0d",
                         e.step, e.sel, a_st, a_ctl, a_ill, a_to, a_cnt, e.st, e.ctl, e.ill, e.to, e.cnt);
            end
        end
    end

    task automatic drive(input logic [5:0] fl, input logic bt, input logic ir, input logic dr);
        {bus_a.is_r_type, bus_a.is_i_type, bus_a.is_load, bus_a.is_store, bus_a.is_branch, bus_a.is_jump} = fl;
        {bus_b.is_r_type, bus_b.is_i_type, bus_b.is_load, bus_b.is_store, bus_b.is_branch, bus_b.is_jump} = fl;
        bus_a.br_taken = bt;  bus_a.imem_ready = ir;  bus_a.dmem_ready = dr;
        bus_b.br_taken = bt;  bus_b.imem_ready = ir;  bus_b.dmem_ready = dr;
    endtask

    task automatic push(input logic [2:0] st, input logic [11:0] ctl);
        exp_t e;
        e.sel = sel;  e.step = step;  e.st = st;  e.ctl = ctl;
        e.ill = exp_ill;  e.to = exp_to;  e.cnt = exp_cnt;
        sb_q.push_back(e);
        step = step + 1;
        if (ctl[0]) exp_cnt = (exp_cnt + 32'd1) & cnt_mask;
    endtask

    // One clock cycle: drive inputs, record the expected outputs for that cycle.
    task automatic cyc(input logic [5:0] fl, input logic bt, input logic ir, input logic dr,
                       input logic [2:0] st, input logic [11:0] ctl);
        drive(fl, bt, ir, dr);
        push(st, ctl);
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        if (sel == 0) rst_n_a = v;
        else          rst_n_b = v;
    endtask

    // Two cycles in reset, release, then the single IDLE cycle.
    task automatic hold_reset();
        set_rst(1'b0);
        exp_ill = 1'b0;  exp_to = 1'b0;  exp_cnt = 32'd0;
        cyc(6'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 12'h000);
        cyc(6'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 12'h000);
        set_rst(1'b1);
        cyc(6'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 12'h000);
    endtask

    task automatic fetch(input logic [5:0] fl, input int nwait);
        for (int k = 0; k < nwait; k++) cyc(fl, 1'b0, 1'b0, 1'b0, C_FETCH, K_IMREQ);
        cyc(fl, 1'b0, 1'b1, 1'b0, C_FETCH, K_IMREQ | K_IRWE);
        cyc(fl, 1'b0, 1'b0, 1'b0, C_DECODE, 12'h000);
    endtask

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        drive(6'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // ---- DUT A: HALT_ON_TRAP=1, 32-bit counter ----
        sel = 0;
        hold_reset();
        // R-type, zero waits
        fetch(F_R, 0);
        cyc(F_R, 1'b0, 1'b0, 1'b0, C_EXEC, 12'h000);
        cyc(F_R, 1'b0, 1'b0, 1'b0, C_WB, K_RFWE | K_PCWE | K_DONE);
        // Load, dmem_ready on the fourth MEM cycle
        fetch(F_LD, 0);
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_EXEC, K_IMM);
        for (int k = 0; k < 3; k++) cyc(F_LD, 1'b0, 1'b0, 1'b0, C_MEM, K_IMM | K_DREQ);
        cyc(F_LD, 1'b0, 1'b0, 1'b1, C_MEM, K_IMM | K_DREQ);
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_WB, K_RFWE | K_WB_LD | K_PCWE | K_DONE);
        // I-type with two fetch waits
        fetch(F_I, 2);
        cyc(F_I, 1'b0, 1'b0, 1'b0, C_EXEC, K_IMM);
        cyc(F_I, 1'b0, 1'b0, 1'b0, C_WB, K_RFWE | K_PCWE | K_DONE);
        // Store with one data wait
        fetch(F_ST, 0);
        cyc(F_ST, 1'b0, 1'b0, 1'b0, C_EXEC, K_IMM);
        cyc(F_ST, 1'b0, 1'b0, 1'b0, C_MEM, K_IMM | K_DREQ | K_DWE);
        cyc(F_ST, 1'b0, 1'b0, 1'b1, C_MEM, K_IMM | K_DREQ | K_DWE | K_PCWE | K_DONE);
        // Branch taken, branch not taken, jump
        fetch(F_BR, 0);
        cyc(F_BR, 1'b1, 1'b0, 1'b0, C_EXEC, K_PCWE | K_PCS_BR | K_DONE);
        fetch(F_BR, 0);
        cyc(F_BR, 1'b0, 1'b0, 1'b0, C_EXEC, K_PCWE | K_DONE);
        fetch(F_JP, 0);
        cyc(F_JP, 1'b0, 1'b0, 1'b0, C_EXEC, K_RFWE | K_WB_PC | K_PCWE | K_PCS_JP | K_DONE);
        // Asynchronous reset in the middle of a MEM wait
        fetch(F_LD, 0);
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_EXEC, K_IMM);
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_MEM, K_IMM | K_DREQ);
        drive(F_LD, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n_a = 1'b0;
        #1;
        checks = checks + 1;
        if (bus_a.state !== C_IDLE || bus_a.dmem_req !== 1'b0 || bus_a.alu_src_imm !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL async reset: state=%0d dmem_req=%0b alu_src_imm=%0b not cleared immediately",
                     bus_a.state, bus_a.dmem_req, bus_a.alu_src_imm);
        end
        exp_ill = 1'b0;  exp_to = 1'b0;  exp_cnt = 32'd0;
        push(C_IDLE, 12'h000);
        @(posedge clk);
        #1;
        hold_reset();
        // No class flag set: trap then halt, imem_req stays low
        fetch(6'd0, 0);
        exp_ill = 1'b1;
        cyc(6'd0, 1'b0, 1'b0, 1'b0, C_TRAP, K_PCWE | K_PCS_TR);
        for (int k = 0; k < 3; k++) cyc(6'd0, 1'b0, 1'b1, 1'b0, C_HALT, 12'h000);
        // Load and store both set
        hold_reset();
        fetch(F_LD | F_ST, 0);
        exp_ill = 1'b1;
        cyc(F_LD | F_ST, 1'b0, 1'b0, 1'b0, C_TRAP, K_PCWE | K_PCS_TR);
        for (int k = 0; k < 3; k++) cyc(F_LD | F_ST, 1'b0, 1'b1, 1'b1, C_HALT, 12'h000);
        checks = checks + 1;
        if (bus_a.illegal !== 1'b1 || bus_a.state !== C_HALT) begin
            failures = failures + 1;
            $display("FAIL sticky illegal: illegal=%0b state=%0d", bus_a.illegal, bus_a.state);
        end

        // ---- DUT B: HALT_ON_TRAP=0, 4-bit counter ----
        rst_n_a  = 1'b0;
        sel      = 1;
        cnt_mask = 32'h0000_000F;
        hold_reset();
        // Fetch timeout after MAX_WAIT+1 cycles without ready
        for (int k = 0; k < 16; k++) cyc(F_BR, 1'b0, 1'b0, 1'b0, C_FETCH, K_IMREQ);
        exp_to = 1'b1;
        cyc(F_BR, 1'b0, 1'b0, 1'b0, C_TRAP, K_PCWE | K_PCS_TR);
        // Sixteen branch retirements wrap the 4-bit counter back to 0
        for (int n = 0; n < 16; n++) begin
            logic bt;
            bt = n[0];
            fetch(F_BR, 0);
            cyc(F_BR, bt, 1'b0, 1'b0, C_EXEC, K_PCWE | (bt ? K_PCS_BR : 12'h000) | K_DONE);
        end
        checks = checks + 1;
        if (bus_b.retired_cnt !== 4'd0) begin
            failures = failures + 1;
            $display("FAIL counter wrap: retired_cnt=%0d expected 0", bus_b.retired_cnt);
        end
        cyc(F_BR, 1'b0, 1'b0, 1'b0, C_FETCH, K_IMREQ);
        // Reset clears sticky timeout; then a data-side timeout
        hold_reset();
        fetch(F_LD, 0);
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_EXEC, K_IMM);
        for (int k = 0; k < 16; k++) cyc(F_LD, 1'b0, 1'b0, 1'b0, C_MEM, K_IMM | K_DREQ);
        exp_to = 1'b1;
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_TRAP, K_PCWE | K_PCS_TR);
        cyc(F_LD, 1'b0, 1'b0, 1'b0, C_FETCH, K_IMREQ);
        checks = checks + 1;
        if (bus_b.timeout !== 1'b1 || bus_b.illegal !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL sticky timeout: timeout=%0b illegal=%0b", bus_b.timeout, bus_b.illegal);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
